// File: rtl/boot_rom_pkg.sv
// Shared types and constants for the boot ROM arbiter: FSM states, port IDs, ROM geometry.
package boot_rom_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

   localparam logic PortI = 1'b0;
   localparam logic PortD = 1'b1;

   localparam int unsigned RomAw       = 10;
   localparam int unsigned RomWinBytes = 4096;
   localparam int unsigned RomPageLsb  = $clog2(RomWinBytes);

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the port not granted last wins.
module rr_arb2
   import boot_rom_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = (last == PortD) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Arbitrates instruction and data read ports onto a single synchronous boot ROM,
// one access outstanding at a time.
module boot_rom_arbiter
   import boot_rom_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned AW        = RomAw
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          i_req_valid,
   output logic          i_req_ready,
   input  logic [31:0]   i_req_addr,
   output logic          i_rsp_valid,
   input  logic          i_rsp_ready,
   output logic [31:0]   i_rsp_data,
   output logic          i_rsp_err,

   input  logic          d_req_valid,
   output logic          d_req_ready,
   input  logic [31:0]   d_req_addr,
   output logic          d_rsp_valid,
   input  logic          d_rsp_ready,
   output logic [31:0]   d_rsp_data,
   output logic          d_rsp_err,

   output logic          rom_ce,
   output logic          rom_oce,
   output logic          rom_reset,
   output logic [AW-1:0] rom_ad,
   input  logic [31:0]   rom_dout
);

   state_e        state_q, state_d;
   logic          last_q;
   logic          gnt_q;
   logic [AW-1:0] rom_ad_q;
   logic [31:0]   data_q;
   logic          err_q;

   logic [1:0]    grant;
   logic [31:0]   sel_addr;
   logic          sel_legal;
   logic          accept;
   logic          rsp_ready_sel;

   rr_arb2 u_rr_arb2 (
      .req   ({d_req_valid, i_req_valid}),
      .last  (last_q),
      .grant (grant)
   );

   // Requests are only accepted from IDLE, and never while reset is asserted.
   always_comb begin
      sel_addr      = grant[1] ? d_req_addr : i_req_addr;
      sel_legal     = (sel_addr[1:0] == 2'b00) &&
                      (sel_addr[31:RomPageLsb] == BASE_ADDR[31:RomPageLsb]);
      accept        = (state_q == StIdle) && !reset && (grant != 2'b00);
      rsp_ready_sel = (gnt_q == PortD) ? d_rsp_ready : i_rsp_ready;

      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = sel_legal ? StIssue : StResp;
         StIssue: state_d = StWait;
         StWait:  state_d = StResp;
         StResp:  if (rsp_ready_sel) state_d = StIdle;
         default: state_d = StIdle;
      endcase

      i_req_ready = accept && grant[0];
      d_req_ready = accept && grant[1];
      i_rsp_valid = (state_q == StResp) && (gnt_q == PortI);
      d_rsp_valid = (state_q == StResp) && (gnt_q == PortD);
      rom_ce      = (state_q == StIssue);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         last_q   <= PortD;
         gnt_q    <= PortI;
         rom_ad_q <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            gnt_q    <= grant[1];
            last_q   <= grant[1];
            rom_ad_q <= sel_addr[AW+1:2];
            if (!sel_legal) begin
               data_q <= '0;
               err_q  <= 1'b1;
            end
         end
         if (state_q == StWait) begin
            data_q <= rom_dout;
            err_q  <= 1'b0;
         end
      end
   end

   assign rom_oce    = 1'b1;
   assign rom_reset  = reset;
   assign rom_ad     = rom_ad_q;
   assign i_rsp_data = data_q;
   assign d_rsp_data = data_q;
   assign i_rsp_err  = err_q;
   assign d_rsp_err  = err_q;

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Self-checking bench for boot_rom_arbiter: table vectors, hand sequences for contention,
// backpressure and mid-access reset, then randomized traffic against a transaction-level model.
module tb_boot_rom_arbiter;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_err;
   logic [31:0]   i_req_addr, i_rsp_data;
   logic          d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_err;
   logic [31:0]   d_req_addr, d_rsp_data;
   logic          rom_ce, rom_oce, rom_reset;
   logic [AW-1:0] rom_ad;
   logic [31:0]   rom_dout;

   logic [31:0]   mem [0:1023];
   int            ce_cnt;
   int            checks = 0;
   int            errors = 0;
   logic          m_last;
   logic [31:0]   last_data;
   logic          last_err;
   int            last_lat;
   int            last_waited;

   boot_rom_arbiter #(
      .BASE_ADDR (32'h0000_0000),
      .AW        (AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_req_valid (i_req_valid),
      .i_req_ready (i_req_ready),
      .i_req_addr  (i_req_addr),
      .i_rsp_valid (i_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .i_rsp_data  (i_rsp_data),
      .i_rsp_err   (i_rsp_err),
      .d_req_valid (d_req_valid),
      .d_req_ready (d_req_ready),
      .d_req_addr  (d_req_addr),
      .d_rsp_valid (d_rsp_valid),
      .d_rsp_ready (d_rsp_ready),
      .d_rsp_data  (d_rsp_data),
      .d_rsp_err   (d_rsp_err),
      .rom_ce      (rom_ce),
      .rom_oce     (rom_oce),
      .rom_reset   (rom_reset),
      .rom_ad      (rom_ad),
      .rom_dout    (rom_dout)
   );

   always #5 clk = ~clk;

   // ROM with one-cycle registered read.
   always_ff @(posedge clk) begin
      if (rom_ce) rom_dout <= mem[rom_ad];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ce_cnt <= 0;
      else if (rom_ce) ce_cnt <= ce_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Transaction-level expectation: window at 0, 4 KiB, word aligned.
   task automatic ref_read(input logic [31:0] a, output logic [31:0] d, output logic e,
                           output int lat);
      if (a[1:0] == 2'b00 && a[31:12] == 20'h0) begin
         d = mem[a[11:2]];
         e = 1'b0;
         lat = 3;
      end else begin
         d = 32'h0;
         e = 1'b1;
         lat = 1;
      end
   endtask

   function automatic logic rsp_valid_of(input logic p);
      return p ? d_rsp_valid : i_rsp_valid;
   endfunction

   function automatic logic [31:0] rsp_data_of(input logic p);
      return p ? d_rsp_data : i_rsp_data;
   endfunction

   function automatic logic rsp_err_of(input logic p);
      return p ? d_rsp_err : i_rsp_err;
   endfunction

   task automatic set_req_valid(input logic p, input logic v);
      if (p) d_req_valid = v;
      else   i_req_valid = v;
   endtask

   task automatic set_rsp_ready(input logic p, input logic v);
      if (p) d_rsp_ready = v;
      else   i_rsp_ready = v;
   endtask

   function automatic logic [31:0] rand_addr();
      int s;
      s = $urandom_range(0, 7);
      if (s < 6) return {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if (s == 6) return {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
      return {20'($urandom_range(1, 20'hFFFFF)), 12'($urandom) & 12'hFFC};
   endfunction

   // Called at a falling edge; serves every requesting port and checks each response.
   task automatic run_txn(input logic vi, input logic vd, input logic [31:0] ai,
                          input logic [31:0] ad, input int bp);
      logic [1:0]  pend;
      logic        w, seen, ee, busy_ok, stable_ok;
      logic [31:0] a, ed, d0;
      int          el, lat, ce0, waited;
      pend = {vd, vi};
      i_req_valid = vi;
      d_req_valid = vd;
      i_req_addr  = ai;
      d_req_addr  = ad;
      i_rsp_ready = (bp == 0);
      d_rsp_ready = (bp == 0);
      while (pend != 2'b00) begin
         w = (pend == 2'b11) ? ~m_last : pend[1];
         a = w ? ad : ai;
         ref_read(a, ed, ee, el);
         #1;
         waited = 0;
         while (!(i_req_ready || d_req_ready) && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
         end
         last_waited = waited;
         seen = i_req_ready || d_req_ready;
         chk("grant_seen", 32'(seen), 32'd1);
         if (!seen) begin
            i_req_valid = 1'b0;
            d_req_valid = 1'b0;
            break;
         end
         chk("grant_onehot", 32'(i_req_ready && d_req_ready), 32'd0);
         chk("grant_port", 32'(d_req_ready), 32'(w));
         ce0 = ce_cnt;
         m_last = w;
         @(negedge clk);
         set_req_valid(w, 1'b0);
         pend[w] = 1'b0;
         lat = 1;
         busy_ok = 1'b1;
         while (!rsp_valid_of(w) && lat < 10) begin
            if (i_req_ready || d_req_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
         end
         chk("other_rsp_low", 32'(rsp_valid_of(~w)), 32'd0);
         chk("rsp_latency", 32'(lat), 32'(el));
         chk("rsp_data", rsp_data_of(w), ed);
         chk("rsp_err", 32'(rsp_err_of(w)), 32'(ee));
         last_data = rsp_data_of(w);
         last_err  = rsp_err_of(w);
         last_lat  = lat;
         d0 = rsp_data_of(w);
         stable_ok = 1'b1;
         for (int j = 0; j < bp; j++) begin
            @(negedge clk);
            if (!rsp_valid_of(w) || rsp_data_of(w) !== d0 || rsp_err_of(w) !== ee ||
                i_req_ready || d_req_ready) stable_ok = 1'b0;
         end
         if (bp > 0) chk("bp_stable", 32'(stable_ok), 32'd1);
         set_rsp_ready(w, 1'b1);
         @(negedge clk);
         chk("rsp_done", 32'(rsp_valid_of(w)), 32'd0);
         chk("busy_no_ready", 32'(busy_ok), 32'd1);
         chk("rom_ce_pulses", 32'(ce_cnt - ce0), ee ? 32'd0 : 32'd1);
         set_rsp_ready(w, bp == 0);
      end
   endtask

   typedef struct {
      logic        port;
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs [7];

   initial begin
      logic got_rsp;
      int   ce_before;

      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem[0] = 32'h3000_02B7;
      mem[1] = 32'h0062_8293;

      vecs[0] = '{1'b0, 32'h0000_0000, 32'h3000_02B7, 1'b0, 3};
      vecs[1] = '{1'b1, 32'h0000_0004, 32'h0062_8293, 1'b0, 3};
      vecs[2] = '{1'b1, 32'h0000_1000, 32'h0000_0000, 1'b1, 1};
      vecs[3] = '{1'b1, 32'h0000_0002, 32'h0000_0000, 1'b1, 1};
      vecs[4] = '{1'b0, 32'h0000_0FFC, 32'hC0DE_03FF, 1'b0, 3};
      vecs[5] = '{1'b0, 32'h0000_0008, 32'hC0DE_0002, 1'b0, 3};
      vecs[6] = '{1'b0, 32'h8000_0004, 32'h0000_0000, 1'b1, 1};

      // Reset with both ports already requesting.
      reset = 1'b1;
      i_req_valid = 1'b1;
      d_req_valid = 1'b1;
      i_req_addr  = 32'h4;
      d_req_addr  = 32'h0;
      i_rsp_ready = 1'b1;
      d_rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_i_req_ready", 32'(i_req_ready), 32'd0);
      chk("rst_d_req_ready", 32'(d_req_ready), 32'd0);
      chk("rst_rsp_valid", 32'({i_rsp_valid, d_rsp_valid}), 32'd0);
      chk("rst_rom_ce", 32'(rom_ce), 32'd0);
      chk("rst_rom_ad", 32'(rom_ad), 32'd0);
      chk("rst_data_err", {i_rsp_data[30:0], i_rsp_err}, 32'd0);
      chk("rom_reset_follows", 32'(rom_reset), 32'd1);
      chk("rom_oce_tied", 32'(rom_oce), 32'd1);

      // Contention straight out of reset: I first, D second.
      reset = 1'b0;
      m_last = 1'b1;
      run_txn(1'b1, 1'b1, 32'h4, 32'h0, 0);
      chk("first_grant_immediate", 32'(rom_reset), 32'd0);
      run_txn(1'b1, 1'b0, 32'h8, 32'h0, 0);
      run_txn(1'b1, 1'b1, 32'h0, 32'hC, 0);
      run_txn(1'b1, 1'b1, 32'h10, 32'h14, 1);

      for (int k = 0; k < 7; k++) begin
         run_txn(~vecs[k].port, vecs[k].port, vecs[k].addr, vecs[k].addr, 0);
         chk("vec_data", last_data, vecs[k].data);
         chk("vec_err", 32'(last_err), 32'(vecs[k].err));
         chk("vec_lat", 32'(last_lat), 32'(vecs[k].lat));
         chk("vec_no_wait", 32'(last_waited), 32'd0);
      end

      // Data-port backpressure, with and without a competing instruction request.
      run_txn(1'b0, 1'b1, 32'h0, 32'h4, 5);
      run_txn(1'b1, 1'b1, 32'h20, 32'h24, 5);

      // Reset during WAIT discards the access.
      i_req_addr  = 32'h4;
      i_req_valid = 1'b1;
      i_rsp_ready = 1'b1;
      #1;
      chk("wr_accept", 32'(i_req_ready), 32'd1);
      @(negedge clk);
      i_req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("wr_rom_ce", 32'(rom_ce), 32'd0);
      chk("wr_rom_ad", 32'(rom_ad), 32'd0);
      chk("wr_rsp_valid", 32'({i_rsp_valid, d_rsp_valid}), 32'd0);
      chk("wr_data_err", {i_rsp_data[30:0], i_rsp_err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      m_last = 1'b1;
      ce_before = ce_cnt;
      got_rsp = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (i_rsp_valid || d_rsp_valid) got_rsp = 1'b1;
      end
      chk("wr_no_rsp_after", 32'(got_rsp), 32'd0);
      chk("wr_no_ce_after", 32'(ce_cnt - ce_before), 32'd0);
      run_txn(1'b1, 1'b0, 32'h4, 32'h0, 0);
      chk("wr_recover_data", last_data, 32'h0062_8293);

      for (int k = 0; k < 40; k++) begin
         logic [1:0] r;
         r = 2'($urandom_range(1, 3));
         run_txn(r[0], r[1], rand_addr(), rand_addr(), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
